// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Control FSM for a multi-cycle MIPS datapath built around one shared ALU, one
//   unified memory and the IR/MDR/A/B/ALUOut registers. Each instruction
//   (R-type, ADDI, LW, SW, SLTI, BEQ, J) is sequenced over 3-5 states. The FSM
//   stalls in memory states until the memory handshake completes, or aborts
//   after MEM_TIMEOUT wait cycles.
//
// Parameters
//   MEM_TIMEOUT    wait cycles tolerated in a memory state before abort (1..255)
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_i          synchronous active-high reset
//   instr_op_i     opcode IR[31:26], valid from DECODE onward
//   zero_i         ALU zero flag; BEQ qualification happens in the datapath
//   mem_ready_i    memory access completes this cycle
//   PCWrite_o      unconditional PC load
//   PCWriteCond_o  PC load qualified by zero_i in the datapath
//   IorD_o         memory address select: 0 PC, 1 ALUOut
//   MemRead_o      memory read request
//   MemWrite_o     memory write request
//   IRWrite_o      IR load
//   MemtoReg_o     RF write data: 0 ALUOut, 1 MDR
//   RegDst_o       RF destination: 0 rt, 1 rd
//   RegWrite_o     RF write enable
//   ALUSrcA_o      ALU A: 0 PC, 1 reg A
//   ALUSrcB_o      ALU B: 00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
//   ALU_op_o       to ALU_Ctrl: 010 R-type, 000 add, 001 sub, 011 slt
//   PCSource_o     PC source: 00 ALU result, 01 ALUOut, 10 jump target
//   state_o        current FSM state (debug / verification)
//   instr_done_o   1-cycle pulse in the final state of each instruction
//   illegal_op_o   1-cycle pulse in DECODE on an unsupported opcode
//   mem_err_o      1-cycle pulse on memory timeout
//
// Memory handshake: in FETCH, MEMRD and MEMWR the controller holds its request
// (MemRead_o or MemWrite_o) high every cycle until mem_ready_i is sampled high
// on a rising edge; that cycle completes the access and the state advances. If
// ready stays low with the wait counter at MEM_TIMEOUT, the request is dropped
// for that cycle, mem_err_o pulses and the FSM returns to FETCH. mem_ready_i is
// ignored in every other state.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       MemtoReg_o,
  output logic       RegDst_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [2:0] ALU_op_o,
  output logic [1:0] PCSource_o,
  output logic [3:0] state_o,
  output logic       instr_done_o,
  output logic       illegal_op_o,
  output logic       mem_err_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_RWB    = 4'd7,
    S_EXEC_I = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_R   = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] cnt_q;
  logic       in_mem;
  logic       timeout;

  // Only the three states that talk to memory count wait cycles.
  assign in_mem  = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                   (state_q == S_MEMWR);
  // A ready on the timeout cycle still completes the access normally.
  assign timeout = in_mem && !mem_ready_i && (cnt_q == TIMEOUT_CNT);

  assign state_o = state_q;

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (instr_op_i)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_RTYPE:         state_d = S_EXEC_R;
          OP_ADDI, OP_SLTI: state_d = S_EXEC_I;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (instr_op_i == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  begin
        if (mem_ready_i)  state_d = S_MEMWB;
        else if (timeout) state_d = S_FETCH;
        else              state_d = S_MEMRD;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  begin
        if (mem_ready_i || timeout) state_d = S_FETCH;
        else                        state_d = S_MEMWR;
      end
      S_EXEC_R: state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_EXEC_I: state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register and wait counter. The counter restarts whenever the state
  // changes, and also on a FETCH timeout, where the state does not change but
  // the retry must get a fresh budget.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || timeout) begin
        cnt_q <= 8'd0;
      end else if (in_mem && !mem_ready_i) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  // Output decode
  always_comb begin
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    ALU_op_o      = ALU_ADD;
    PCSource_o    = 2'b00;
    instr_done_o  = 1'b0;
    illegal_op_o  = 1'b0;
    mem_err_o     = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC + 4 is computed alongside the fetch and loaded on completion.
        MemRead_o = !timeout;
        ALUSrcB_o = 2'b01;
        IRWrite_o = mem_ready_i;
        PCWrite_o = mem_ready_i;
        mem_err_o = timeout;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        ALUSrcB_o = 2'b11;
        case (instr_op_i)
          OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_SLTI, OP_BEQ, OP_J:
                   illegal_op_o = 1'b0;
          default: illegal_op_o = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
      end
      S_MEMRD: begin
        MemRead_o = !timeout;
        IorD_o    = 1'b1;
        mem_err_o = timeout;
      end
      S_MEMWB: begin
        RegWrite_o   = 1'b1;
        MemtoReg_o   = 1'b1;
        instr_done_o = 1'b1;
      end
      S_MEMWR: begin
        MemWrite_o   = !timeout;
        IorD_o       = 1'b1;
        instr_done_o = mem_ready_i;
        mem_err_o    = timeout;
      end
      S_EXEC_R: begin
        ALUSrcA_o = 1'b1;
        ALU_op_o  = ALU_R;
      end
      S_RWB: begin
        RegWrite_o   = 1'b1;
        RegDst_o     = 1'b1;
        instr_done_o = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        ALU_op_o  = (instr_op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_IWB: begin
        RegWrite_o   = 1'b1;
        instr_done_o = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA_o     = 1'b1;
        ALU_op_o      = ALU_SUB;
        PCWriteCond_o = 1'b1;
        PCSource_o    = 2'b01;
        instr_done_o  = 1'b1;
      end
      S_JUMP: begin
        PCWrite_o    = 1'b1;
        PCSource_o   = 2'b10;
        instr_done_o = 1'b1;
      end
      default: begin
        PCWrite_o = 1'b0;
      end
    endcase

    // Reset overrides everything: no architectural writes, no memory write
    // and no status pulses while rst_i is high.
    if (rst_i) begin
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      MemWrite_o    = 1'b0;
      IRWrite_o     = 1'b0;
      RegWrite_o    = 1'b0;
      instr_done_o  = 1'b0;
      illegal_op_o  = 1'b0;
      mem_err_o     = 1'b0;
    end
  end

  // zero_i is consumed by the datapath's PCWriteCond gating, not here.
  logic unused_zero;
  assign unused_zero = zero_i;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed-vector bench for multicycle_ctrl. Inputs change 1 ns after the
//   rising edge and outputs are sampled 1 ns later, well clear of the edge.
//   Expected values are hand-derived from the instruction sequences.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic       done, illegal, mem_err;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .instr_op_i    (op),
    .zero_i        (zero),
    .mem_ready_i   (ready),
    .PCWrite_o     (pc_write),
    .PCWriteCond_o (pc_write_cond),
    .IorD_o        (iord),
    .MemRead_o     (mem_read),
    .MemWrite_o    (mem_write),
    .IRWrite_o     (ir_write),
    .MemtoReg_o    (mem_to_reg),
    .RegDst_o      (reg_dst),
    .RegWrite_o    (reg_write),
    .ALUSrcA_o     (alu_src_a),
    .ALUSrcB_o     (alu_src_b),
    .ALU_op_o      (alu_op),
    .PCSource_o    (pc_source),
    .state_o       (state),
    .instr_done_o  (done),
    .illegal_op_o  (illegal),
    .mem_err_o     (mem_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Checking
  task automatic check_vec(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; op = 6'h00; zero = 1'b0; ready = 1'b1;
    step(); step();
    settle();
    check_vec("rst_state", 32'(state), 32'd0);
    check_vec("rst_done", 32'(done), 32'd0);
    check_vec("rst_irwrite", 32'(ir_write), 32'd0);
    check_vec("rst_err", 32'(mem_err), 32'd0);
    rst = 1'b0;

    // 1: R-type 0,1,6,7,0
    settle();
    check_vec("r_fetch_state", 32'(state), 32'd0);
    check_vec("r_fetch_memread", 32'(mem_read), 32'd1);
    check_vec("r_fetch_irwrite", 32'(ir_write), 32'd1);
    check_vec("r_fetch_pcwrite", 32'(pc_write), 32'd1);
    check_vec("r_fetch_srcb", 32'(alu_src_b), 32'd1);
    step(); settle();
    check_vec("r_decode_state", 32'(state), 32'd1);
    check_vec("r_decode_srcb", 32'(alu_src_b), 32'd3);
    check_vec("r_decode_illegal", 32'(illegal), 32'd0);
    step(); settle();
    check_vec("r_exec_state", 32'(state), 32'd6);
    check_vec("r_exec_aluop", 32'(alu_op), 32'b010);
    check_vec("r_exec_srca", 32'(alu_src_a), 32'd1);
    check_vec("r_exec_srcb", 32'(alu_src_b), 32'd0);
    check_vec("r_exec_regwrite", 32'(reg_write), 32'd0);
    check_vec("r_exec_done", 32'(done), 32'd0);
    step(); settle();
    check_vec("r_wb_state", 32'(state), 32'd7);
    check_vec("r_wb_regwrite", 32'(reg_write), 32'd1);
    check_vec("r_wb_regdst", 32'(reg_dst), 32'd1);
    check_vec("r_wb_done", 32'(done), 32'd1);
    step(); settle();
    check_vec("r_end_state", 32'(state), 32'd0);
    check_vec("r_end_done", 32'(done), 32'd0);

    // 2: LW with three stall cycles in MEMRD
    op = 6'h23;
    step(); settle();
    check_vec("lw_decode_state", 32'(state), 32'd1);
    step(); settle();
    check_vec("lw_memadr_state", 32'(state), 32'd2);
    check_vec("lw_memadr_srcb", 32'(alu_src_b), 32'd2);
    check_vec("lw_memadr_srca", 32'(alu_src_a), 32'd1);
    step();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_vec("lw_memrd_state", 32'(state), 32'd3);
      check_vec("lw_memrd_memread", 32'(mem_read), 32'd1);
      check_vec("lw_memrd_iord", 32'(iord), 32'd1);
      step();
    end
    ready = 1'b1;
    settle();
    check_vec("lw_memrd_last_state", 32'(state), 32'd3);
    check_vec("lw_memrd_last_memread", 32'(mem_read), 32'd1);
    step(); settle();
    check_vec("lw_memwb_state", 32'(state), 32'd4);
    check_vec("lw_memwb_memtoreg", 32'(mem_to_reg), 32'd1);
    check_vec("lw_memwb_regwrite", 32'(reg_write), 32'd1);
    check_vec("lw_memwb_regdst", 32'(reg_dst), 32'd0);
    check_vec("lw_memwb_done", 32'(done), 32'd1);
    step(); settle();
    check_vec("lw_end_state", 32'(state), 32'd0);

    // 3: BEQ then J
    op = 6'h04;
    step(); step(); settle();
    check_vec("beq_state", 32'(state), 32'd10);
    check_vec("beq_pcwritecond", 32'(pc_write_cond), 32'd1);
    check_vec("beq_pcsource", 32'(pc_source), 32'd1);
    check_vec("beq_aluop", 32'(alu_op), 32'b001);
    check_vec("beq_done", 32'(done), 32'd1);
    check_vec("beq_pcwrite", 32'(pc_write), 32'd0);
    step(); settle();
    check_vec("beq_end_state", 32'(state), 32'd0);
    op = 6'h02;
    step(); step(); settle();
    check_vec("j_state", 32'(state), 32'd11);
    check_vec("j_pcwrite", 32'(pc_write), 32'd1);
    check_vec("j_pcsource", 32'(pc_source), 32'd2);
    check_vec("j_done", 32'(done), 32'd1);
    step(); settle();
    check_vec("j_end_state", 32'(state), 32'd0);

    // 4: SLTI then illegal opcode
    op = 6'h0a;
    step(); step(); settle();
    check_vec("slti_exec_state", 32'(state), 32'd8);
    check_vec("slti_exec_aluop", 32'(alu_op), 32'b011);
    check_vec("slti_exec_srcb", 32'(alu_src_b), 32'd2);
    step(); settle();
    check_vec("slti_iwb_state", 32'(state), 32'd9);
    check_vec("slti_iwb_regwrite", 32'(reg_write), 32'd1);
    check_vec("slti_iwb_regdst", 32'(reg_dst), 32'd0);
    check_vec("slti_iwb_done", 32'(done), 32'd1);
    step(); settle();
    op = 6'h08;
    step(); step(); settle();
    check_vec("addi_exec_aluop", 32'(alu_op), 32'b000);
    step(); step(); settle();
    op = 6'h3f;
    step(); settle();
    check_vec("ill_state", 32'(state), 32'd1);
    check_vec("ill_pulse", 32'(illegal), 32'd1);
    check_vec("ill_regwrite", 32'(reg_write), 32'd0);
    step(); settle();
    check_vec("ill_next_state", 32'(state), 32'd0);
    check_vec("ill_pulse_clear", 32'(illegal), 32'd0);

    // 5: SW timeout after 15 wait cycles
    op = 6'h2b;
    step(); step(); step();
    ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      settle();
      check_vec("sw_wait_state", 32'(state), 32'd5);
      check_vec("sw_wait_memwrite", 32'(mem_write), 32'd1);
      check_vec("sw_wait_err", 32'(mem_err), 32'd0);
      check_vec("sw_wait_done", 32'(done), 32'd0);
      step();
    end
    settle();
    check_vec("sw_to_state", 32'(state), 32'd5);
    check_vec("sw_to_err", 32'(mem_err), 32'd1);
    check_vec("sw_to_memwrite", 32'(mem_write), 32'd0);
    check_vec("sw_to_done", 32'(done), 32'd0);
    step();
    ready = 1'b1;
    settle();
    check_vec("sw_to_next_state", 32'(state), 32'd0);
    check_vec("sw_to_err_clear", 32'(mem_err), 32'd0);

    // 5b: ready arriving on the timeout cycle completes normally
    step(); step(); step();
    ready = 1'b0;
    for (int i = 0; i < 15; i++) step();
    ready = 1'b1;
    settle();
    check_vec("sw_late_state", 32'(state), 32'd5);
    check_vec("sw_late_done", 32'(done), 32'd1);
    check_vec("sw_late_err", 32'(mem_err), 32'd0);
    check_vec("sw_late_memwrite", 32'(mem_write), 32'd1);
    step(); settle();
    check_vec("sw_late_next_state", 32'(state), 32'd0);

    // 5c: FETCH timeout retries FETCH with a fresh counter
    ready = 1'b0;
    for (int i = 0; i < 15; i++) step();
    settle();
    check_vec("fetch_to_err", 32'(mem_err), 32'd1);
    check_vec("fetch_to_memread", 32'(mem_read), 32'd0);
    check_vec("fetch_to_irwrite", 32'(ir_write), 32'd0);
    step(); settle();
    check_vec("fetch_retry_state", 32'(state), 32'd0);
    check_vec("fetch_retry_err", 32'(mem_err), 32'd0);
    check_vec("fetch_retry_memread", 32'(mem_read), 32'd1);
    ready = 1'b1;

    // 6: reset in MEMWR with ready low
    step(); step(); step();
    ready = 1'b0;
    step(); settle();
    check_vec("rst_mid_pre_state", 32'(state), 32'd5);
    rst = 1'b1;
    settle();
    check_vec("rst_mid_memwrite_gated", 32'(mem_write), 32'd0);
    check_vec("rst_mid_done_gated", 32'(done), 32'd0);
    step(); settle();
    check_vec("rst_mid_state", 32'(state), 32'd0);
    check_vec("rst_mid_memwrite", 32'(mem_write), 32'd0);
    check_vec("rst_mid_done", 32'(done), 32'd0);
    check_vec("rst_mid_err", 32'(mem_err), 32'd0);
    rst = 1'b0;
    ready = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
